// File: rtl/daisy_frm_pkg.sv
// Shared definitions for the daisy-chain frame decoder.
package daisy_frm_pkg;

  localparam logic [7:0]  SOF_BYTE  = 8'hA5;
  localparam logic [15:0] FILL_WORD = 16'h00FF;

  typedef enum logic [1:0] {
    IDLE,
    PAY,
    CSUM,
    DROP
  } frm_state_t;

  // True when the upper byte carries the start-of-frame marker.
  function automatic logic is_sof(input logic [15:0] w);
    return w[15:8] == SOF_BYTE;
  endfunction

endpackage

// File: rtl/red_pitaya_daisy_cfifo.sv
// Commit/rollback FIFO: writes stay invisible to the reader until committed.
module red_pitaya_daisy_cfifo #(
  parameter int DEPTH = 64,
  parameter int W     = 17
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr,
  input  logic [W-1:0]             wr_data,
  input  logic                     commit,
  input  logic                     rollback,
  input  logic                     rd,
  output logic [W-1:0]             rd_data,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   free
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] commit_ptr;
  logic [PW-1:0] rd_ptr;

  // Storage array, no reset needed: reads are masked by valid.
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // Pointer bookkeeping; read and commit are independent so both act in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
    end else begin
      if (rollback)  wr_ptr <= commit_ptr;
      else if (wr)   wr_ptr <= wr_ptr + PW'(1);
      if (commit)    commit_ptr <= wr_ptr;
      if (rd && valid) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // First-word-fall-through read side and free-space report.
  always_comb begin
    valid   = (rd_ptr != commit_ptr);
    rd_data = mem[rd_ptr[AW-1:0]];
    free    = PW'(DEPTH) - (wr_ptr - rd_ptr);
  end

endmodule

// File: rtl/red_pitaya_daisy_deframer.sv
// Frame decoder: validates header/checksum and forwards only intact payloads.
module red_pitaya_daisy_deframer
  import daisy_frm_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int MAX_LEN = 32,
  parameter int TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        rx_trained_i,
  input  logic        rx_dv_i,
  input  logic [15:0] rx_dat_i,
  output logic        m_valid_o,
  output logic [15:0] m_data_o,
  output logic        m_last_o,
  input  logic        m_ready_i,
  output logic        frm_ok_o,
  output logic        frm_err_o,
  output logic [15:0] ok_cnt_o,
  output logic [15:0] err_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  frm_state_t    state, state_n;
  logic [15:0]   sum;
  logic [7:0]    remaining;
  logic [8:0]    drop_cnt;
  logic [TW-1:0] idle_cnt;

  logic [7:0]    len;
  logic          hdr, fits, abort;
  logic          f_wr, f_commit, f_rollback, f_valid;
  logic [16:0]   f_wdata, f_rdata;
  logic [AW:0]   f_free;
  logic          hdr_load, pay_acc, drop_dec, ok_ev, err_ev;

  red_pitaya_daisy_cfifo #(
    .DEPTH (DEPTH),
    .W     (17)
  ) u_fifo (
    .clk      (clk_i),
    .rst_n    (rstn_i),
    .wr       (f_wr),
    .wr_data  (f_wdata),
    .commit   (f_commit),
    .rollback (f_rollback),
    .rd       (m_ready_i),
    .rd_data  (f_rdata),
    .valid    (f_valid),
    .free     (f_free)
  );

  // Next-state logic and FIFO control.
  always_comb begin
    state_n    = state;
    f_wr       = 1'b0;
    f_wdata    = {1'b0, rx_dat_i};
    f_commit   = 1'b0;
    f_rollback = 1'b0;
    hdr_load   = 1'b0;
    pay_acc    = 1'b0;
    drop_dec   = 1'b0;
    ok_ev      = 1'b0;
    err_ev     = 1'b0;

    len   = rx_dat_i[7:0];
    hdr   = rx_dv_i && rx_trained_i && is_sof(rx_dat_i) &&
            (len != 8'd0) && (16'(len) <= 16'(MAX_LEN));
    fits  = 16'(f_free) >= 16'(len);
    abort = (state != IDLE) && (!rx_trained_i || idle_cnt == TW'(TIMEOUT));

    unique case (state)
      IDLE: begin
        if (hdr) begin
          hdr_load = 1'b1;
          if (fits) begin
            // Re-anchor the write pointer at the committed boundary.
            f_rollback = 1'b1;
            state_n    = PAY;
          end else begin
            err_ev  = 1'b1;
            state_n = DROP;
          end
        end
      end
      PAY: begin
        if (abort) begin
          f_rollback = 1'b1;
          err_ev     = 1'b1;
          state_n    = IDLE;
        end else if (rx_dv_i) begin
          f_wr    = 1'b1;
          f_wdata = {remaining == 8'd1, rx_dat_i};
          pay_acc = 1'b1;
          if (remaining == 8'd1) state_n = CSUM;
        end
      end
      CSUM: begin
        if (abort) begin
          f_rollback = 1'b1;
          err_ev     = 1'b1;
          state_n    = IDLE;
        end else if (rx_dv_i) begin
          if (rx_dat_i == sum) begin
            f_commit = 1'b1;
            ok_ev    = 1'b1;
          end else begin
            f_rollback = 1'b1;
            err_ev     = 1'b1;
          end
          state_n = IDLE;
        end
      end
      DROP: begin
        if (abort) begin
          state_n = IDLE;
        end else if (rx_dv_i) begin
          drop_dec = 1'b1;
          if (drop_cnt == 9'd1) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register, checksum/length datapath, pulses and saturating counters.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state     <= IDLE;
      sum       <= '0;
      remaining <= '0;
      drop_cnt  <= '0;
      idle_cnt  <= '0;
      frm_ok_o  <= 1'b0;
      frm_err_o <= 1'b0;
      ok_cnt_o  <= '0;
      err_cnt_o <= '0;
    end else begin
      state     <= state_n;
      frm_ok_o  <= ok_ev;
      frm_err_o <= err_ev;
      if (hdr_load) begin
        sum       <= rx_dat_i;
        remaining <= len;
        drop_cnt  <= 9'(len) + 9'd1;
      end
      if (pay_acc) begin
        sum       <= sum + rx_dat_i;
        remaining <= remaining - 8'd1;
      end
      if (drop_dec) drop_cnt <= drop_cnt - 9'd1;
      if (state == IDLE || rx_dv_i) idle_cnt <= '0;
      else                          idle_cnt <= idle_cnt + TW'(1);
      if (ok_ev && ok_cnt_o != '1)   ok_cnt_o  <= ok_cnt_o + 16'd1;
      if (err_ev && err_cnt_o != '1) err_cnt_o <= err_cnt_o + 16'd1;
    end
  end

  // Stream outputs are zeroed while nothing committed is pending.
  always_comb begin
    m_valid_o = f_valid;
    m_data_o  = f_valid ? f_rdata[15:0] : '0;
    m_last_o  = f_valid & f_rdata[16];
  end

endmodule

// File: doc/red_pitaya_daisy_deframer.md
# red_pitaya_daisy_deframer

Frame decoder directly downstream of the daisy-chain RX deserializer. Consumes its trained 16-bit parallel word stream (valid strobes only, no backpressure), recognises framed packets, verifies a 16-bit checksum and forwards only intact payloads to local logic over a valid/ready stream. Payload is held store-and-forward in a commit/rollback FIFO, so corrupt, truncated or oversize frames never reach the consumer.

## Interface
- `DEPTH`, 64: FIFO depth in words, power of two, ≥ `MAX_LEN`.
- `MAX_LEN`, 32: largest legal payload length in words, 1..255.
- `TIMEOUT`, 255: maximum idle cycles between two words of one frame before the frame is aborted.
- `clk_i`  in  1  parallel clock, the BUFG'd RX parallel clock.
- `rstn_i`  in  1  reset; **asynchronous, active-low**, single clock domain.
- `rx_trained_i`  in  1  link-trained flag from the RX deserializer.
- `rx_dv_i`  in  1  input word strobe.
- `rx_dat_i`  in  16  input word.
- `m_valid_o`  out  1  output word valid.
- `m_data_o`  out  16  output payload word.
- `m_last_o`  out  1  last payload word of frame.
- `m_ready_i`  in  1  consumer ready.
- `frm_ok_o`  out  1  one-cycle pulse, frame committed.
- `frm_err_o`  out  1  one-cycle pulse, frame discarded.
- `ok_cnt_o`  out  16  committed frames, saturating.
- `err_cnt_o`  out  16  discarded frames (checksum, abort, overflow), saturating.

## Operation
- Frame format: header `{8'hA5, len}`, then `len` payload words, then a checksum word equal to the sum mod 2^16 of the header and all payload words.
- **IDLE**:
  - A word with `rx_dv_i`, `rx_trained_i`, upper byte `8'hA5` and `len` in 1..`MAX_LEN` is a header.
  - Every other word (fill `16'h00FF`, zero, bad length) is ignored silently, no error.
  - On a header, check FIFO free space (`DEPTH` − (`wr_ptr` − `rd_ptr`)):
    - If free space ≥ `len`: snapshot `commit_ptr` into `wr_ptr`, load `sum` = header, load `remaining` = `len`, go to **PAY**.
    - Otherwise: go to **DROP**, pulse `frm_err_o`, increment `err_cnt_o`.
- **PAY**: each strobed word is written at `wr_ptr` with its last bit set when `remaining` == 1, added to `sum`, and `remaining` decrements. After the last word, go to **CSUM**.
- **CSUM**: the next strobed word is compared with `sum`.
  - Match: `commit_ptr` ← `wr_ptr`, pulse `frm_ok_o`, increment `ok_cnt_o`.
  - Mismatch: `wr_ptr` ← `commit_ptr` (rollback), pulse `frm_err_o`, increment `err_cnt_o`.
  - Either way, return to **IDLE**.
- **DROP**: count down `len`+1 strobed words without writing them, then return to **IDLE**.
- Abort: in PAY or CSUM, if `rx_trained_i` falls or the idle counter reaches `TIMEOUT`, roll back, pulse `frm_err_o`, increment `err_cnt_o` and go to **IDLE**. In DROP the same conditions return to IDLE without a second error.
- Read side: `m_valid_o` = (`rd_ptr` != `commit_ptr`). The output is first-word-fall-through from the array at `rd_ptr`, and `rd_ptr` advances on `m_valid_o && m_ready_i`.
- Counters saturate at `16'hFFFF`.

## Timing
- Reset values: every output 0, pointers 0, state IDLE, `sum` 0.
- Checksum word strobed in cycle T:
  - `frm_ok_o` or `frm_err_o` high in T+1 only.
  - `commit_ptr` updated at T+1.
  - `m_valid_o` rises in T+1 if the FIFO previously held no committed data.
- The read side never exposes uncommitted words. A read and a commit in the same cycle are both honoured.
- Rollback never moves `wr_ptr` below `rd_ptr` (guaranteed, since `commit_ptr` ≥ `rd_ptr`).
- Consecutive strobes on back-to-back cycles must be supported. The upstream deserializer gives one strobe per 4 cycles, which is not a limit.
- A header arriving in the same cycle the previous frame commits is impossible, because CSUM consumes that word.
- Pointers are log2(`DEPTH`)+1 bits wide; the extra bit distinguishes full from empty. Pointer arithmetic wraps.
- Reset asserted mid-frame discards everything, including committed but unread data.

## Structure
- Package `daisy_frm_pkg`: `SOF_BYTE = 8'hA5`, `FILL_WORD = 16'h00FF`, and a state enum (`IDLE`, `PAY`, `CSUM`, `DROP`).
- Sub-module `red_pitaya_daisy_cfifo`: a 17-bit wide FIFO with ports `wr`, `commit` and `rollback`, which exposes free space. The FSM, checksum, timeout and counters live in the top level.

## Test plan
- Header `A503`, payload `0001 0002 0003`, checksum `A509` → three words out, `m_last_o` on `0003`, one `frm_ok_o` pulse, `ok_cnt_o` = 1.
- Same frame with checksum `A50A` → no `m_valid_o`, one `frm_err_o` pulse, `err_cnt_o` = 1, then a good frame passes intact.
- `m_ready_i` held low, 4 frames of len 16 with `DEPTH` = 64 → 4 commit; a 5th frame is dropped with `err_cnt_o` = 1. Draining then yields exactly 64 words in order.
- `rx_trained_i` dropped after 2 of 5 payload words → `frm_err_o` pulse, and earlier committed frames are still readable unchanged.
- Fill words `00FF` and header `A500` in IDLE → no output, no error pulse, no counter change.
- Gap of `TIMEOUT` cycles mid-payload → abort with `err_cnt_o` +1, and the following valid frame is accepted.
